// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus an independent debounce counter per switch bit.
// Produces stable switch levels, one-cycle rise/fall events and a one-hot flag.
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SWITCHES,
  output logic [WIDTH-1:0] CLEAN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED,
  output logic             ONEHOT
);

  localparam logic [CNT_W-1:0] lastCount = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] syncS1;
  logic [WIDTH-1:0] syncS2;
  logic [CNT_W-1:0] count [WIDTH];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      syncS1 <= '0;
      syncS2 <= '0;
    end else begin
      syncS1 <= SWITCHES;
      syncS2 <= syncS1;
    end
  end

  // Any cycle where the synchronized bit agrees with CLEAN restarts the window,
  // so a single glitch costs a full DEBOUNCE_CYCLES wait.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      CLEAN <= '0;
      RISE  <= '0;
      FALL  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        count[i] <= '0;
      end
    end else begin
      RISE <= '0;
      FALL <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (syncS2[i] == CLEAN[i]) begin
          count[i] <= '0;
        end else if (count[i] == lastCount) begin
          count[i] <= '0;
          CLEAN[i] <= syncS2[i];
          RISE[i]  <= syncS2[i];
          FALL[i]  <= ~syncS2[i];
        end else begin
          count[i] <= count[i] + CNT_W'(1);
        end
      end
    end
  end

  assign CHANGED = |(RISE | FALL);
  assign ONEHOT  = (CLEAN != '0) && ((CLEAN & (CLEAN - WIDTH'(1))) == '0);

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a per-cycle reference model feeding a scoreboard,
// a table of held-input vectors with hand-derived results, and latency/bounce sequences.
module tb_switch_debouncer;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic             CLOCK;
  logic             RESET;
  logic [WIDTH-1:0] SWITCHES;
  logic [WIDTH-1:0] CLEAN;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             CHANGED;
  logic             ONEHOT;

  switch_debouncer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .SWITCHES(SWITCHES),
    .CLEAN(CLEAN),
    .RISE(RISE),
    .FALL(FALL),
    .CHANGED(CHANGED),
    .ONEHOT(ONEHOT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
    logic             onehot;
  } outRec_t;

  typedef struct {
    logic [WIDTH-1:0] sw;
    int               hold;
    outRec_t          exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  outRec_t expQ [$];

  // Reference model: run length of consecutive edges the synchronized bit has disagreed.
  logic [WIDTH-1:0] mS1, mS2, mClean, mRise, mFall;
  int               mRun [WIDTH];

  function automatic outRec_t mkRec(logic [WIDTH-1:0] c, logic [WIDTH-1:0] r, logic [WIDTH-1:0] f);
    outRec_t o;
    o.clean   = c;
    o.rise    = r;
    o.fall    = f;
    o.changed = |(r | f);
    o.onehot  = ($countones(c) == 1);
    return o;
  endfunction

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mClean = '0; mRise = '0; mFall = '0;
    for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
  endtask

  task automatic modelStep();
    logic [WIDTH-1:0] nClean;
    if (RESET) begin
      modelReset();
    end else begin
      nClean = mClean;
      mRise  = '0;
      mFall  = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (mS2[i] != mClean[i]) begin
          mRun[i]++;
          if (mRun[i] >= DEB) begin
            nClean[i] = mS2[i];
            if (mS2[i]) mRise[i] = 1'b1;
            else        mFall[i] = 1'b1;
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      mClean = nClean;
      mS2    = mS1;
      mS1    = SWITCHES;
    end
  endtask

  function automatic outRec_t dutRec();
    outRec_t o;
    o.clean   = CLEAN;
    o.rise    = RISE;
    o.fall    = FALL;
    o.changed = CHANGED;
    o.onehot  = ONEHOT;
    return o;
  endfunction

  task automatic checkOutput(input string name, input outRec_t exp);
    outRec_t act;
    act = dutRec();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got clean=%b rise=%b fall=%b chg=%b oh=%b, want clean=%b rise=%b fall=%b chg=%b oh=%b",
               name, act.clean, act.rise, act.fall, act.changed, act.onehot,
               exp.clean, exp.rise, exp.fall, exp.changed, exp.onehot);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive at the falling edge, advance the model on the rising edge, compare 1 time unit later.
  task automatic applyStimulus(input logic [WIDTH-1:0] sw, input logic rst);
    outRec_t exp;
    @(negedge CLOCK);
    SWITCHES = sw;
    RESET    = rst;
    if (rst) begin
      #1;
      checkOutput("async_reset", mkRec('0, '0, '0));
    end
    @(posedge CLOCK);
    modelStep();
    expQ.push_back(mkRec(mClean, mRise, mFall));
    #1;
    if (expQ.size() == 0) begin
      checkValue("scoreboard_empty", 0, 1);
    end else begin
      exp = expQ.pop_front();
      checkOutput("scoreboard", exp);
    end
  endtask

  vec_t vecs [12];

  initial begin
    int firstEdge;
    int pulses;
    logic [WIDTH-1:0] sw;

    vecs[0]  = '{4'b0000, 6, mkRec(4'b0000, 4'b0000, 4'b1111)};
    vecs[1]  = '{4'b0000, 1, mkRec(4'b0000, 4'b0000, 4'b0000)};
    vecs[2]  = '{4'b0100, 5, mkRec(4'b0000, 4'b0000, 4'b0000)};
    vecs[3]  = '{4'b0100, 1, mkRec(4'b0100, 4'b0100, 4'b0000)};
    vecs[4]  = '{4'b0100, 1, mkRec(4'b0100, 4'b0000, 4'b0000)};
    vecs[5]  = '{4'b0000, 5, mkRec(4'b0100, 4'b0000, 4'b0000)};
    vecs[6]  = '{4'b0000, 1, mkRec(4'b0000, 4'b0000, 4'b0100)};
    vecs[7]  = '{4'b0000, 1, mkRec(4'b0000, 4'b0000, 4'b0000)};
    vecs[8]  = '{4'b0011, 6, mkRec(4'b0011, 4'b0011, 4'b0000)};
    vecs[9]  = '{4'b0011, 1, mkRec(4'b0011, 4'b0000, 4'b0000)};
    vecs[10] = '{4'b0000, 6, mkRec(4'b0000, 4'b0000, 4'b0011)};
    vecs[11] = '{4'b0000, 2, mkRec(4'b0000, 4'b0000, 4'b0000)};

    RESET    = 1'b1;
    SWITCHES = 4'b1111;
    modelReset();

    // Reset held with all switches on, then measure latency to CLEAN=1111.
    for (int c = 0; c < 3; c++) applyStimulus(4'b1111, 1'b1);
    firstEdge = 0;
    for (int e = 1; e <= 12 && firstEdge == 0; e++) begin
      applyStimulus(4'b1111, 1'b0);
      if (CLEAN == 4'b1111) begin
        firstEdge = e;
        checkOutput("reset_release_rise", mkRec(4'b1111, 4'b1111, 4'b0000));
      end
    end
    checkValue("reset_release_latency", firstEdge, 6);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("reset_release_pulse_end", mkRec(4'b1111, 4'b0000, 4'b0000));

    // Held-input vectors: press, release and multi-bit change.
    for (int v = 0; v < 12; v++) begin
      for (int c = 0; c < vecs[v].hold; c++) applyStimulus(vecs[v].sw, 1'b0);
      checkOutput($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Bounce on bit 0: 1,1,1,0 then 1 held; s2 settles at edge 6, CLEAN at edge 10.
    firstEdge = 0;
    pulses    = 0;
    for (int e = 1; e <= 14; e++) begin
      sw = (e == 4) ? 4'b0000 : 4'b0001;
      applyStimulus(sw, 1'b0);
      if (RISE[0]) pulses++;
      if (CLEAN[0] && firstEdge == 0) firstEdge = e;
    end
    checkValue("bounce_clean_edge", firstEdge, 10);
    checkValue("bounce_rise_pulses", pulses, 1);

    for (int c = 0; c < 7; c++) applyStimulus(4'b0000, 1'b0);
    checkOutput("bounce_return", mkRec(4'b0000, 4'b0000, 4'b0000));

    // Reset with the bit-3 counter at 2, then the full latency is required again.
    for (int c = 0; c < 4; c++) applyStimulus(4'b1000, 1'b0);
    checkOutput("midcount_before_reset", mkRec(4'b0000, 4'b0000, 4'b0000));
    applyStimulus(4'b1000, 1'b1);
    checkOutput("midcount_in_reset", mkRec(4'b0000, 4'b0000, 4'b0000));
    firstEdge = 0;
    for (int e = 1; e <= 12 && firstEdge == 0; e++) begin
      applyStimulus(4'b1000, 1'b0);
      if (CLEAN == 4'b1000) begin
        firstEdge = e;
        checkOutput("midcount_rise", mkRec(4'b1000, 4'b1000, 4'b0000));
      end
    end
    checkValue("midcount_latency", firstEdge, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
